master_rx_descramble_ctrl: RTL and testbench

//  Receive-side counterpart of the MAC transmit scrambling control. It sits between the PIPE Rx

---
 rtl/master_rx_descramble_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_master_rx_descramble_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/master_rx_descramble_ctrl.sv
// Rx-side descrambler control: decodes Gen1/2 K-codes and Gen3 128b/130b block framing
// into per-byte LFSR advance / XOR enable / reseed controls, aligned with delayed Rx data.
module master_rx_descramble_ctrl #(
  parameter int unsigned BLOCK_SYMS = 16,
  parameter int unsigned MAX_BYTES  = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [2:0]             GEN,
  input  logic [5:0]             PIPEWIDTH,
  input  logic                   turnOff,
  input  logic                   rxValid,
  input  logic [8*MAX_BYTES-1:0] rxData,
  input  logic [MAX_BYTES-1:0]   rxDataK,
  input  logic [1:0]             rxSyncHeader,
  input  logic                   rxStartBlock,
  output logic [8*MAX_BYTES-1:0] rxDataQ,
  output logic                   rxValidQ,
  output logic [1:0]             LFSRSel,
  output logic [MAX_BYTES-1:0]   advance,
  output logic [MAX_BYTES-1:0]   descramblingEnable,
  output logic                   patternReset,
  output logic                   alignError,
  output logic                   syncError
);

  localparam int unsigned CNT_W = $clog2(BLOCK_SYMS);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned NB_W  = $clog2(MAX_BYTES) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA_BLK  = 3'd1,
    SKP_BLK   = 3'd2,
    EIEOS_BLK = 3'd3,
    TS_BLK    = 3'd4,
    OS_BLK    = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt, w_state_eff, w_blk;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_eff, w_base;
  logic [2:0]         r_gen;
  logic [5:0]         r_pw;
  logic               r_cfg_vld;
  logic               w_cfg_chg;
  logic [NB_W-1:0]    w_nbytes;
  logic [MAX_BYTES-1:0] w_mask;
  logic [1:0]         w_sel;
  logic [SUM_W-1:0]   w_sum;
  logic [MAX_BYTES-1:0] w_adv, w_en;
  logic               w_pr, w_align, w_sync;

  // Beat width decode: valid byte count, byte mask and LFSR width select
  always_comb begin
    w_nbytes = NB_W'(MAX_BYTES);
    w_sel    = 2'd2;
    w_mask   = '0;
    if (PIPEWIDTH == 6'd8) begin
      w_nbytes = NB_W'(1);
      w_sel    = 2'd0;
    end else if (PIPEWIDTH == 6'd16) begin
      w_nbytes = NB_W'(2);
      w_sel    = 2'd1;
    end
    for (int i = 0; i < MAX_BYTES; i++) begin
      w_mask[i] = (NB_W'(i) < w_nbytes);
    end
  end

  // Next-state and next-output logic; a GEN/PIPEWIDTH change restarts framing this beat
  always_comb begin
    w_cfg_chg   = r_cfg_vld && ((GEN != r_gen) || (PIPEWIDTH != r_pw));
    w_state_eff = w_cfg_chg ? IDLE : r_state;
    w_cnt_eff   = w_cfg_chg ? '0 : r_cnt;
    w_state_nxt = w_state_eff;
    w_cnt_nxt   = w_cnt_eff;
    w_blk       = IDLE;
    w_base      = w_cnt_eff;
    w_sum       = '0;
    w_adv       = '0;
    w_en        = '0;
    w_pr        = 1'b0;
    w_align     = 1'b0;
    w_sync      = 1'b0;

    if (turnOff) begin
      w_pr        = 1'b1;
      w_adv       = w_mask;
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (rxValid) begin
      if (GEN < 3'd3) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (w_mask[i]) begin
            w_en[i]  = ~rxDataK[i];
            w_adv[i] = ~(rxDataK[i] && (rxData[8*i +: 8] == 8'h1C));
            if (rxDataK[i] && (rxData[8*i +: 8] == 8'hBC)) begin
              w_pr = 1'b1;
            end
          end
        end
      end else begin
        if (rxStartBlock) begin
          w_align = (w_cnt_eff != '0);
          w_base  = '0;
          case (rxSyncHeader)
            2'b01: w_blk = DATA_BLK;
            2'b10: begin
              case (rxData[7:0])
                8'hAA:        w_blk = SKP_BLK;
                8'h00:        w_blk = EIEOS_BLK;
                8'h1E, 8'h2D: w_blk = TS_BLK;
                default:      w_blk = OS_BLK;
              endcase
            end
            default: w_sync = 1'b1;
          endcase
        end else begin
          w_blk   = w_state_eff;
          w_align = (w_state_eff == IDLE) && !w_cfg_chg;
        end

        w_sum = SUM_W'(w_base) + SUM_W'(w_nbytes);
        if (w_blk != IDLE) begin
          for (int i = 0; i < MAX_BYTES; i++) begin
            if (w_mask[i]) begin
              case (w_blk)
                DATA_BLK: begin
                  w_adv[i] = 1'b1;
                  w_en[i]  = 1'b1;
                end
                SKP_BLK: ;
                TS_BLK: begin
                  w_adv[i] = 1'b1;
                  w_en[i]  = !((w_base == '0) && (i == 0));
                end
                default: w_adv[i] = 1'b1;
              endcase
            end
          end
          w_pr = (w_blk == EIEOS_BLK) && (w_sum >= SUM_W'(BLOCK_SYMS));
          if (w_sum >= SUM_W'(BLOCK_SYMS)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = w_blk;
            w_cnt_nxt   = w_sum[CNT_W-1:0];
          end
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state            <= IDLE;
      r_cnt              <= '0;
      r_gen              <= '0;
      r_pw               <= '0;
      r_cfg_vld          <= 1'b0;
      rxDataQ            <= '0;
      rxValidQ           <= 1'b0;
      LFSRSel            <= '0;
      advance            <= '0;
      descramblingEnable <= '0;
      patternReset       <= 1'b0;
      alignError         <= 1'b0;
      syncError          <= 1'b0;
    end else begin
      r_state            <= w_state_nxt;
      r_cnt              <= w_cnt_nxt;
      r_gen              <= GEN;
      r_pw               <= PIPEWIDTH;
      r_cfg_vld          <= 1'b1;
      rxDataQ            <= rxData;
      rxValidQ           <= rxValid;
      LFSRSel            <= w_sel;
      advance            <= w_adv;
      descramblingEnable <= w_en;
      patternReset       <= w_pr;
      alignError         <= w_align;
      syncError          <= w_sync;
    end
  end

endmodule

// File: tb/tb_master_rx_descramble_ctrl.sv
// Scoreboard bench for master_rx_descramble_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops one per valid output beat.
module tb_master_rx_descramble_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  GEN;
  logic [5:0]  PIPEWIDTH;
  logic        turnOff;
  logic        rxValid;
  logic [31:0] rxData;
  logic [3:0]  rxDataK;
  logic [1:0]  rxSyncHeader;
  logic        rxStartBlock;
  logic [31:0] rxDataQ;
  logic        rxValidQ;
  logic [1:0]  LFSRSel;
  logic [3:0]  advance;
  logic [3:0]  descramblingEnable;
  logic        patternReset;
  logic        alignError;
  logic        syncError;

  master_rx_descramble_ctrl dut (
    .clk                (clk),
    .resetn             (resetn),
    .GEN                (GEN),
    .PIPEWIDTH          (PIPEWIDTH),
    .turnOff            (turnOff),
    .rxValid            (rxValid),
    .rxData             (rxData),
    .rxDataK            (rxDataK),
    .rxSyncHeader       (rxSyncHeader),
    .rxStartBlock       (rxStartBlock),
    .rxDataQ            (rxDataQ),
    .rxValidQ           (rxValidQ),
    .LFSRSel            (LFSRSel),
    .advance            (advance),
    .descramblingEnable (descramblingEnable),
    .patternReset       (patternReset),
    .alignError         (alignError),
    .syncError          (syncError)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          idx;
    logic [31:0] data;
    logic [1:0]  sel;
    logic [3:0]  adv;
    logic [3:0]  en;
    logic        pr;
    logic        al;
    logic        sy;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bidx     = 0;

  // Monitor: every valid output beat must match the oldest queued expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && rxValidQ === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got valid output adv=%b en=%b, required no output", advance, descramblingEnable);
      end else begin
        m_e = q.pop_front();
        if (rxDataQ !== m_e.data || LFSRSel !== m_e.sel || advance !== m_e.adv ||
            descramblingEnable !== m_e.en || patternReset !== m_e.pr ||
            alignError !== m_e.al || syncError !== m_e.sy) begin
          n_fail++;
          $display("FAIL t%0d_beat%0d: got data=%h sel=%0d adv=%b en=%b pr=%b al=%b sy=%b, required data=%h sel=%0d adv=%b en=%b pr=%b al=%b sy=%b",
                   m_e.tag, m_e.idx, rxDataQ, LFSRSel, advance, descramblingEnable, patternReset,
                   alignError, syncError, m_e.data, m_e.sel, m_e.adv, m_e.en, m_e.pr, m_e.al, m_e.sy);
        end
      end
    end
  end

  task automatic beat(input int tag, input logic [2:0] g, input logic [5:0] pw, input logic [31:0] d,
                      input logic [3:0] k, input logic [1:0] sh, input logic st, input logic to,
                      input logic [3:0] ea, input logic [3:0] ee, input logic epr, input logic eal,
                      input logic esy, input bit push);
    exp_t x;
    @(negedge clk);
    GEN = g; PIPEWIDTH = pw; rxData = d; rxDataK = k; rxSyncHeader = sh;
    rxStartBlock = st; turnOff = to; rxValid = 1'b1;
    if (push) begin
      x.tag = tag; x.idx = bidx; x.data = d;
      x.sel = (pw == 6'd8) ? 2'd0 : (pw == 6'd16) ? 2'd1 : 2'd2;
      x.adv = ea; x.en = ee; x.pr = epr; x.al = eal; x.sy = esy;
      q.push_back(x);
    end
    bidx++;
  endtask

  task automatic g3(input int tag, input logic [5:0] pw, input logic [31:0] d, input logic [1:0] sh,
                    input logic st, input logic [3:0] ea, input logic [3:0] ee, input logic epr,
                    input logic eal, input logic esy);
    beat(tag, 3'd3, pw, d, 4'h0, sh, st, 1'b0, ea, ee, epr, eal, esy, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxValid = 1'b0; turnOff = 1'b0; rxStartBlock = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; GEN = 3'd1; PIPEWIDTH = 6'd32; turnOff = 1'b0; rxValid = 1'b1;
    rxData = 32'hDEADBEEF; rxDataK = 4'hF; rxSyncHeader = 2'b00; rxStartBlock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rxDataQ, rxValidQ, LFSRSel, advance, descramblingEnable, patternReset, alignError, syncError} !== 47'd0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h v=%b adv=%b en=%b pr=%b, required all zero",
               rxDataQ, rxValidQ, advance, descramblingEnable, patternReset);
    end
    @(negedge clk);
    rxValid = 1'b0; resetn = 1'b1;
    idle(2);

    // Gen1/2 K-code handling and byte masking
    beat(1, 3'd1, 6'd32, 32'h1C1C1CBC, 4'hF, 2'b00, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(1, 3'd2, 6'd16, 32'hFFFF1C55, 4'b0010, 2'b00, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
    beat(1, 3'd1, 6'd8, 32'h000000BC, 4'b0001, 2'b00, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(1, 3'd1, 6'd8, 32'h0000BC00, 4'b0010, 2'b00, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
    beat(1, 3'd1, 6'd32, 32'h12345678, 4'h0, 2'b00, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Gen3 W32 SKP block then data block, then an unframed beat
    g3(2, 6'd32, 32'h000000AA, 2'b10, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) g3(2, 6'd32, 32'hAAAAAAAA, 2'b10, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    g3(2, 6'd32, 32'h44332211, 2'b01, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) g3(2, 6'd32, 32'h55667788 + i, 2'b01, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    g3(2, 6'd32, 32'h0BADF00D, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Gen3 W8 EIEOS: reseed only with symbol 15
    for (int i = 0; i < 16; i++)
      g3(3, 6'd8, 32'h00000000, 2'b10, (i == 0), 4'b0001, 4'b0000, (i == 15), 1'b0, 1'b0);

    // Gen3 W16 TS1: symbol 0 not descrambled
    g3(4, 6'd16, 32'h00004A1E, 2'b10, 1'b1, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) g3(4, 6'd16, 32'h00004A4A, 2'b10, 1'b0, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);

    // Gen3 W8 early block start at symbol 8 reopens as SKP
    for (int i = 0; i < 8; i++) g3(5, 6'd8, 32'h00000010 + i, 2'b01, (i == 0), 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    g3(5, 6'd8, 32'h000000AA, 2'b10, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) g3(5, 6'd8, 32'h000000AA, 2'b10, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    g3(5, 6'd8, 32'h00000077, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Bad sync headers
    g3(7, 6'd32, 32'h00000001, 2'b11, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    g3(7, 6'd32, 32'h00000002, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    g3(7, 6'd32, 32'h00000003, 2'b00, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Generic OS and TS2 blocks at W32
    g3(11, 6'd32, 32'h00000055, 2'b10, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) g3(11, 6'd32, 32'h55555555, 2'b10, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    g3(11, 6'd32, 32'h4A4A4A2D, 2'b10, 1'b1, 4'hF, 4'b1110, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) g3(11, 6'd32, 32'h4A4A4A4A, 2'b10, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);

    // turnOff mid-block forces reset of framing
    g3(8, 6'd16, 32'h0000ABCD, 2'b01, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);
    beat(8, 3'd3, 6'd16, 32'h0000BCBC, 4'h0, 2'b01, 1'b0, 1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    g3(8, 6'd16, 32'h00001234, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Invalid beats hold the symbol count
    g3(9, 6'd32, 32'h90909090, 2'b01, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) g3(9, 6'd32, 32'h91000000 + i, 2'b01, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    g3(9, 6'd32, 32'h92000000, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Width change mid-block drops framing silently
    g3(10, 6'd32, 32'hA0A0A0A0, 2'b01, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    g3(10, 6'd16, 32'hA1A1A1A1, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    g3(10, 6'd16, 32'hA2A2A2A2, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Async reset in the middle of a data block
    g3(6, 6'd32, 32'hCAFEF00D, 2'b01, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    beat(6, 3'd3, 6'd32, 32'hCAFEF00E, 4'h0, 2'b01, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    n_checks++;
    if (advance !== 4'hF || rxValidQ !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got adv=%b v=%b, required adv=1111 v=1", advance, rxValidQ);
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({rxDataQ, rxValidQ, LFSRSel, advance, descramblingEnable, patternReset, alignError, syncError} !== 47'd0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%h v=%b adv=%b en=%b, required all zero",
               rxDataQ, rxValidQ, advance, descramblingEnable);
    end
    rxValid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    idle(1);
    g3(6, 6'd32, 32'h00000099, 2'b01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

    idle(3);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
